regfile_write_arbiter: RTL

Shares the single write port of the 32 x 8-bit register file between two requesters: the core writeback path and the debug/host load path. Issues a registered, round-robin-fair grant with a one-cycle write pulse, and can optionally zero the whole register file after reset. Sits directly in front of the register file's `Write_register`/`Write_data`/`RegWrite` inputs. Read ports are not touched.

---
 rtl/regfile_write_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single write port of the register file between the core
// writeback path and the debug/host load path. It issues a registered,
// round-robin grant with a one-cycle write pulse.
// Optional feature macro: REGFILE_CLEAR_EN. When this macro is defined,
// every register is zeroed after reset, before any grant is issued.
module regfile_write_arbiter #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 8
) (
    input  logic          ph1,
    input  logic          reset,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_data,
    output logic          core_gnt,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_data,
    output logic          dbg_gnt,
    output logic [AW-1:0] Write_register,
    output logic [DW-1:0] Write_data,
    output logic          RegWrite,
    output logic          busy
);

    // The clear counter must be able to address every register it clears.
    if (NREGS == 0 || NREGS > (2 ** AW)) begin : g_nregs_range
        $error("NREGS must be in 1..2**AW");
    end

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_e;

    req_e          last_q, last_d;
    logic          core_gnt_q, core_gnt_d;
    logic          dbg_gnt_q, dbg_gnt_d;
    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] wreg_q, wreg_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          core_elig;
    logic          dbg_elig;
    logic          pick_core;
    logic          pick_dbg;

    // IDLE arbitration: the requester granted this cycle is excluded. This lets it drop req,
    // and it prevents back-to-back grants to the same side.
    always_comb begin
        core_elig  = core_req & ~core_gnt_q;
        dbg_elig   = dbg_req & ~dbg_gnt_q;
        pick_core  = core_elig & (~dbg_elig | (last_q == REQ_DBG));
        pick_dbg   = dbg_elig & (~core_elig | (last_q == REQ_CORE));

        core_gnt_d = pick_core;
        dbg_gnt_d  = pick_dbg;
        regwrite_d = pick_core | pick_dbg;
        last_d     = last_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (pick_core) begin
            last_d  = REQ_CORE;
            wreg_d  = core_addr;
            wdata_d = core_data;
        end else if (pick_dbg) begin
            last_d  = REQ_DBG;
            wreg_d  = dbg_addr;
            wdata_d = dbg_data;
        end
    end

`ifdef REGFILE_CLEAR_EN

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    // Controller: sweeps zero-writes over every register after reset, then arbitrates.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            last_q     <= REQ_DBG;
            core_gnt_q <= 1'b0;
            dbg_gnt_q  <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // Requests are not acknowledged here, so they remain pending.
                    core_gnt_q <= 1'b0;
                    dbg_gnt_q  <= 1'b0;
                    regwrite_q <= 1'b1;
                    wreg_q     <= cnt_q;
                    wdata_q    <= '0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    core_gnt_q <= core_gnt_d;
                    dbg_gnt_q  <= dbg_gnt_d;
                    regwrite_q <= regwrite_d;
                    wreg_q     <= wreg_d;
                    wdata_q    <= wdata_d;
                    last_q     <= last_d;
                end
            endcase
        end
    end

    assign busy = busy_q;

`else

    // Arbiter registers: with no clear sequence, the arbiter is idle from reset onward.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            last_q     <= REQ_DBG;
            core_gnt_q <= 1'b0;
            dbg_gnt_q  <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            core_gnt_q <= core_gnt_d;
            dbg_gnt_q  <= dbg_gnt_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
        end
    end

    assign busy = 1'b0;

`endif

    assign core_gnt       = core_gnt_q;
    assign dbg_gnt        = dbg_gnt_q;
    assign RegWrite       = regwrite_q;
    assign Write_register = wreg_q;
    assign Write_data     = wdata_q;

endmodule
